s16_to_p1024_reader: RTL and testbench

//  Input-side counterpart of the PE result serializer. It reads 64 consecutive 16-bit words from

---
 rtl/s16_to_p1024_reader_if.sv | 34 +++
 rtl/s16_to_p1024_reader.sv | 96 +++++++++
 tb/tb_s16_to_p1024_reader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/s16_to_p1024_reader_if.sv
// rtl/s16_to_p1024_reader_if.sv - controller, PE-side and Avalon read-master signals of the vector reader
interface s16_to_p1024_reader_if #(
    parameter int WORDS  = 64,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15
);
    logic                      start_control;
    logic [ADDR_W-1:0]         addr_in_control;
    logic                      busy_control;
    logic [WORDS*DATA_W-1:0]   dataout_pe;
    logic                      valid_pe;
    logic                      ready_pe;
    logic [ADDR_W-1:0]         address_input;
    logic                      read_input;
    logic                      chipselect;
    logic [1:0]                byteenable_input;
    logic                      waitrequest_input;
    logic [DATA_W-1:0]         readdata_input;
    logic                      readdatavalid_input;

    modport master (
        input  start_control, addr_in_control, ready_pe,
               waitrequest_input, readdata_input, readdatavalid_input,
        output busy_control, dataout_pe, valid_pe,
               address_input, read_input, chipselect, byteenable_input
    );

    modport slave (
        output start_control, addr_in_control, ready_pe,
               waitrequest_input, readdata_input, readdatavalid_input,
        input  busy_control, dataout_pe, valid_pe,
               address_input, read_input, chipselect, byteenable_input
    );
endinterface

// File: rtl/s16_to_p1024_reader.sv
// rtl/s16_to_p1024_reader.sv - burst-reads WORDS memory words and presents them as one wide vector
module s16_to_p1024_reader #(
    parameter int WORDS     = 64,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 15,
    parameter int ADDR_STEP = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    s16_to_p1024_reader_if.master bus
);
    localparam int CNT_W = $clog2(WORDS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, HOLD} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        issue_cnt;
    logic [CNT_W-1:0]        rx_cnt;
    logic [ADDR_W-1:0]       addr_reg;
    logic                    read_q;
    logic                    valid_q;
    logic                    busy_q;
    logic [WORDS*DATA_W-1:0] data_q;
    logic                    capture;
    logic                    accept;

    // Responses are only collected while a burst is live and the vector still has room
    assign capture = (state == READ || state == DRAIN) && bus.readdatavalid_input && (rx_cnt < CNT_FULL);
    assign accept  = (state == READ) && read_q && !bus.waitrequest_input;

    assign bus.address_input    = addr_reg;
    assign bus.read_input       = read_q;
    assign bus.chipselect       = read_q;
    assign bus.byteenable_input = 2'b11;
    assign bus.valid_pe         = valid_q;
    assign bus.busy_control     = busy_q;
    assign bus.dataout_pe       = data_q;

    // Burst FSM: issue requests, collect in-order responses, hold the vector until the PE takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            rx_cnt    <= '0;
            addr_reg  <= '0;
            read_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            data_q    <= '0;
        end else begin
            if (capture) begin
                data_q[DATA_W*int'(rx_cnt) +: DATA_W] <= bus.readdata_input;
                rx_cnt <= rx_cnt + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (bus.start_control) begin
                        addr_reg  <= bus.addr_in_control;
                        data_q    <= '0;
                        issue_cnt <= '0;
                        rx_cnt    <= '0;
                        read_q    <= 1'b1;
                        busy_q    <= 1'b1;
                        state     <= READ;
                    end
                end
                READ: begin
                    if (accept) begin
                        issue_cnt <= issue_cnt + CNT_W'(1);
                        addr_reg  <= addr_reg + ADDR_W'(ADDR_STEP);
                        if (issue_cnt == CNT_LAST) begin
                            read_q <= 1'b0;
                            state  <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (capture && rx_cnt == CNT_LAST) begin
                        valid_q <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.ready_pe) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_s16_to_p1024_reader.sv
// tb/tb_s16_to_p1024_reader.sv - self-checking bench for s16_to_p1024_reader
module tb_s16_to_p1024_reader;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    s16_to_p1024_reader_if ifc ();
    s16_to_p1024_reader dut (.clk(clk), .rst(rst), .bus(ifc));

    typedef struct {
        int          ready;
        logic [15:0] data;
    } resp_t;

    typedef struct {
        logic [14:0] base;
        logic [15:0] key;
        int          wait_pct;
        int          lat_max;
        int          rdy_delay;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
    } vec_t;

    logic [14:0] addr_log[$];
    resp_t       pend[$];
    int          cyc       = 0;
    int          last_rdy  = -1;
    int          wait_pct  = 0;
    int          lat_max   = 1;
    logic [15:0] key       = 16'h0000;

    function automatic logic [15:0] mem_word(input logic [14:0] a, input logic [15:0] k);
        return 16'({1'b0, a} >> 1) ^ k;
    endfunction

    function automatic logic [1023:0] model_vec(input logic [14:0] base, input logic [15:0] k);
        logic [1023:0] v;
        logic [14:0]   a;
        v = '0;
        for (int i = 0; i < 64; i++) begin
            a = 15'((32'(base) + 2 * i) % 32768);
            v[16*i +: 16] = mem_word(a, k);
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Avalon slave: random stalls, in-order responses after 1..lat_max cycles
    initial begin
        int r;
        ifc.waitrequest_input   = 1'b0;
        ifc.readdatavalid_input = 1'b0;
        ifc.readdata_input      = '0;
        forever begin
            @(negedge clk);
            if (ifc.read_input && !ifc.waitrequest_input) begin
                addr_log.push_back(ifc.address_input);
                r = cyc + $urandom_range(1, lat_max);
                if (r <= last_rdy) r = last_rdy + 1;
                last_rdy = r;
                pend.push_back('{ready: r, data: mem_word(ifc.address_input, key)});
            end
            @(posedge clk);
            #1;
            cyc++;
            ifc.waitrequest_input = ($urandom_range(0, 99) < wait_pct);
            if (pend.size() > 0 && pend[0].ready <= cyc) begin
                ifc.readdatavalid_input = 1'b1;
                ifc.readdata_input      = pend[0].data;
                void'(pend.pop_front());
            end else begin
                ifc.readdatavalid_input = 1'b0;
                ifc.readdata_input      = 16'($urandom);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic run_burst(input logic [14:0] base, input int rdy_delay, input bit hold_start,
                             output logic [1023:0] got, output int lat);
        logic [1023:0] exp_v;
        int            n;
        int            addr_bad;
        bit            stable;
        bit            quiet;
        exp_v = model_vec(base, key);
        addr_log.delete();
        ifc.ready_pe        = (rdy_delay == 0);
        ifc.start_control   = 1'b1;
        ifc.addr_in_control = base;
        tick();
        ifc.start_control   = 1'b0;
        chk("busy_after_start", ifc.busy_control, 1);
        n = 0;
        while (!ifc.valid_pe && n < 3000) begin
            tick();
            n++;
        end
        lat = n;
        chk("valid_seen", ifc.valid_pe, 1);
        got    = ifc.dataout_pe;
        stable = 1'b1;
        for (int i = 0; i < rdy_delay; i++) begin
            ifc.start_control   = hold_start && (i == rdy_delay / 2);
            ifc.addr_in_control = 15'h4444;
            tick();
            ifc.start_control   = 1'b0;
            if (!ifc.valid_pe || ifc.dataout_pe !== got || !ifc.busy_control || ifc.read_input) stable = 1'b0;
        end
        if (rdy_delay > 0) chk("hold_stable", stable, 1);
        ifc.ready_pe        = 1'b1;
        ifc.start_control   = hold_start;
        ifc.addr_in_control = 15'h4444;
        tick();
        ifc.ready_pe      = 1'b0;
        ifc.start_control = 1'b0;
        chk("valid_after_hs", ifc.valid_pe, 0);
        chk("busy_after_hs", ifc.busy_control, 0);
        chk("n_reads", addr_log.size(), 64);
        addr_bad = 0;
        for (int i = 0; i < addr_log.size() && i < 64; i++)
            if (addr_log[i] !== 15'((32'(base) + 2 * i) % 32768)) addr_bad++;
        chk("addr_seq_errors", addr_bad, 0);
        chk("vector", got, exp_v);
        if (hold_start) begin
            quiet = 1'b1;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (ifc.busy_control || ifc.read_input || ifc.valid_pe) quiet = 1'b0;
            end
            chk("no_restart_from_hold", quiet, 1);
        end
    endtask

    initial begin
        vec_t          tbl[5];
        logic [1023:0] got;
        logic [1023:0] v1;
        int            lat;
        int            n;
        bit            quiet;

        tbl[0] = '{15'h0100, 16'h0000, 0,  1, 0, 16'h0080, 16'h00BF};
        tbl[1] = '{15'h0100, 16'h0000, 50, 4, 0, 16'h0080, 16'h00BF};
        tbl[2] = '{15'h7FFC, 16'h0000, 30, 2, 3, 16'h3FFE, 16'h003D};
        tbl[3] = '{15'h2000, 16'h5A5A, 20, 3, 1, 16'h4A5A, 16'h4A65};
        tbl[4] = '{15'h0000, 16'hFFFF, 0,  1, 2, 16'hFFFF, 16'hFFC0};

        rst                 = 1'b1;
        ifc.start_control   = 1'b0;
        ifc.addr_in_control = '0;
        ifc.ready_pe        = 1'b0;
        repeat (3) tick();
        chk("rst_valid", ifc.valid_pe, 0);
        chk("rst_busy", ifc.busy_control, 0);
        chk("rst_read", ifc.read_input, 0);
        chk("rst_cs", ifc.chipselect, 0);
        chk("rst_be", ifc.byteenable_input, 2'b11);
        chk("rst_addr", ifc.address_input, 0);
        chk("rst_data", ifc.dataout_pe, 0);
        rst = 1'b0;
        tick();

        for (int t = 0; t < 5; t++) begin
            wait_pct = tbl[t].wait_pct;
            lat_max  = tbl[t].lat_max;
            key      = tbl[t].key;
            run_burst(tbl[t].base, tbl[t].rdy_delay, 1'b0, got, lat);
            chk($sformatf("first_word_%0d", t), got[15:0], tbl[t].exp_first);
            chk($sformatf("last_word_%0d", t), got[1023:1008], tbl[t].exp_last);
            if (tbl[t].wait_pct == 0 && tbl[t].lat_max == 1) chk("latency_edges", lat, 65);
        end

        for (int t = 0; t < 6; t++) begin
            wait_pct = $urandom_range(0, 60);
            lat_max  = $urandom_range(1, 4);
            key      = 16'($urandom);
            run_burst(15'($urandom_range(0, 16383) * 2), $urandom_range(0, 5), 1'b0, got, lat);
        end

        // backpressure with start pulses during HOLD and on the handshake cycle
        wait_pct = 20;
        lat_max  = 2;
        key      = 16'h0000;
        run_burst(15'h0100, 20, 1'b1, got, lat);

        // reset mid-burst with responses still in flight
        wait_pct = 40;
        lat_max  = 4;
        key      = 16'hA5A5;
        addr_log.delete();
        ifc.start_control   = 1'b1;
        ifc.addr_in_control = 15'h0300;
        tick();
        ifc.start_control = 1'b0;
        n = 0;
        while (addr_log.size() < 30 && n < 1000) begin
            tick();
            n++;
        end
        chk("reached_30_reads", addr_log.size() >= 30, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_read", ifc.read_input, 0);
        chk("midrst_valid", ifc.valid_pe, 0);
        chk("midrst_busy", ifc.busy_control, 0);
        quiet = 1'b1;
        n = 0;
        while ((pend.size() > 0 || n < 3) && n < 60) begin
            tick();
            n++;
            if (ifc.busy_control || ifc.read_input || ifc.valid_pe || ifc.dataout_pe !== '0) quiet = 1'b0;
        end
        chk("late_resp_ignored", quiet, 1);
        key = 16'h1234;
        run_burst(15'h0000, 1, 1'b0, got, lat);

        // back-to-back bursts: second start in the cycle right after the handshake
        wait_pct = 25;
        lat_max  = 3;
        key      = 16'h0F0F;
        run_burst(15'h1000, 0, 1'b0, v1, lat);
        key = 16'h3C3C;
        run_burst(15'h5000, 2, 1'b0, got, lat);
        chk("b2b_independent", got ^ v1, model_vec(15'h5000, 16'h3C3C) ^ model_vec(15'h1000, 16'h0F0F));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
